// File: rtl/mem_bus_arbiter.sv
// CPU memory bus arbiter: exec/fetch arbitration with fetch starvation guard,
// plus the OAM DMA sequencer that halts the CPU and copies one page to OAM.
module mem_bus_arbiter #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    REG_WIDTH    = 8,
   parameter logic [ADDR_WIDTH-1:0] OAM_PORT     = 16'h2004,
   parameter int                    DMA_LEN      = 256,
   parameter int                    STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   input  logic                  exec_req,
   input  logic                  exec_we,
   input  logic [ADDR_WIDTH-1:0] exec_addr,
   input  logic [REG_WIDTH-1:0]  exec_wdata,
   output logic                  exec_gnt,
   input  logic                  dma_start,
   input  logic [REG_WIDTH-1:0]  dma_page,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_we,
   output logic [REG_WIDTH-1:0]  bus_wdata,
   input  logic [REG_WIDTH-1:0]  bus_rdata,
   output logic [1:0]            rdata_owner,
   output logic                  cpu_halt,
   output logic                  dma_busy
);

   localparam int IDX_W = 8;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} dma_state_e;

   dma_state_e           state_q, state_d;
   logic [REG_WIDTH-1:0] page_q, page_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
   logic                 parity_q, parity_d;
   logic [1:0]           rdata_owner_q, rdata_owner_d;

   logic                  starve_win;
   logic [ADDR_WIDTH-1:0] read_addr;

   assign starve_win = (starve_cnt_q == SW'(STARVE_LIMIT)) && fetch_req;
   assign read_addr  = ADDR_WIDTH'({page_q, idx_q});

   // Grants: gated by reset so nothing reaches memory while reset_n is low.
   always_comb begin
      fetch_gnt = 1'b0;
      exec_gnt  = 1'b0;
      if (reset_n) begin
         case (state_q)
            S_IDLE: begin
               if (exec_req && !starve_win) exec_gnt = 1'b1;
               else if (fetch_req)          fetch_gnt = 1'b1;
            end
            S_HALT:  exec_gnt = exec_req && exec_we;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus_addr  = fetch_addr;
      bus_we    = 1'b0;
      bus_wdata = '0;
      if (exec_gnt) begin
         bus_addr  = exec_addr;
         bus_we    = exec_we;
         bus_wdata = exec_we ? exec_wdata : '0;
      end else if (reset_n && state_q == S_READ) begin
         bus_addr = read_addr;
      end else if (reset_n && state_q == S_WRITE) begin
         bus_addr  = OAM_PORT;
         bus_we    = 1'b1;
         bus_wdata = bus_rdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      idx_d    = idx_q;
      parity_d = ~parity_q;
      case (state_q)
         S_IDLE: begin
            if (dma_start) begin
               page_d  = dma_page;
               idx_d   = '0;
               state_d = S_HALT;
            end
         end
         // Wait out any store still being granted, then align to the read slot.
         S_HALT: begin
            if (!(exec_req && exec_we)) state_d = parity_q ? S_ALIGN : S_READ;
         end
         S_ALIGN: state_d = S_READ;
         S_READ:  state_d = S_WRITE;
         S_WRITE: begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == IDX_W'(DMA_LEN - 1)) ? S_IDLE : S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!fetch_req || fetch_gnt)                starve_cnt_d = '0;
      else if (starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_comb begin
      rdata_owner_d = 2'd0;
      if (fetch_gnt)                   rdata_owner_d = 2'd1;
      else if (exec_gnt && !exec_we)   rdata_owner_d = 2'd2;
      else if (state_q == S_READ)      rdata_owner_d = 2'd3;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         page_q        <= '0;
         idx_q         <= '0;
         starve_cnt_q  <= '0;
         parity_q      <= 1'b0;
         rdata_owner_q <= 2'd0;
      end else begin
         state_q       <= state_d;
         page_q        <= page_d;
         idx_q         <= idx_d;
         starve_cnt_q  <= starve_cnt_d;
         parity_q      <= parity_d;
         rdata_owner_q <= rdata_owner_d;
      end
   end

   assign rdata_owner = rdata_owner_q;
   assign cpu_halt    = (state_q != S_IDLE);
   assign dma_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, starvation guard, OAM DMA
// with and without alignment, HALT store completion and reset mid-DMA.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_gnt;
   logic        exec_req;
   logic        exec_we;
   logic [15:0] exec_addr;
   logic [7:0]  exec_wdata;
   logic        exec_gnt;
   logic        dma_start;
   logic [7:0]  dma_page;
   logic [15:0] bus_addr;
   logic        bus_we;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic [1:0]  rdata_owner;
   logic        cpu_halt;
   logic        dma_busy;

   logic [7:0]  wmem [0:65535];
   logic        tb_par;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .exec_req    (exec_req),
      .exec_we     (exec_we),
      .exec_addr   (exec_addr),
      .exec_wdata  (exec_wdata),
      .exec_gnt    (exec_gnt),
      .dma_start   (dma_start),
      .dma_page    (dma_page),
      .bus_addr    (bus_addr),
      .bus_we      (bus_we),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .rdata_owner (rdata_owner),
      .cpu_halt    (cpu_halt),
      .dma_busy    (dma_busy)
   );

   // Memory: page 0x02 reads back its low address byte; everything else is RAM.
   // tb_par follows the arbiter's free-running parity bit.
   always @(posedge clk) begin
      if (bus_we) wmem[bus_addr] <= bus_wdata;
      bus_rdata <= (bus_addr[15:8] == 8'h02) ? bus_addr[7:0] : wmem[bus_addr];
      tb_par    <= reset_n ? ~tb_par : 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_req = 1'b0;
      exec_req  = 1'b0;
      exec_we   = 1'b0;
      dma_start = 1'b0;
   endtask

   // Runs from the first HALT cycle until the DMA goes idle.
   task automatic run_dma(input int exp_len, input int exp_first);
      int n;
      int wcnt;
      int first;
      n     = 0;
      wcnt  = 0;
      first = -1;
      while (dma_busy === 1'b1 && n < 600) begin
         #1;
         chk("dma_halt", {31'd0, cpu_halt}, 32'd1);
         chk("dma_no_fetch", {31'd0, fetch_gnt}, 32'd0);
         if (bus_we === 1'b1) begin
            chk("dma_waddr", {16'd0, bus_addr}, 32'h2004);
            chk("dma_wdata", {24'd0, bus_wdata}, {24'd0, wcnt[7:0]});
            wcnt++;
         end else if (first < 0 && bus_addr === 16'h0200) begin
            first = n;
         end
         n++;
         cyc();
      end
      chk("dma_len", n, exp_len);
      chk("dma_writes", wcnt, 256);
      chk("dma_first_read", first, exp_first);
   endtask

   initial begin
      logic [5:0] exp_e;
      int         wcnt6;
      int         n6;
      logic       found;

      idle_inputs();
      fetch_addr = 16'h0000;
      exec_addr  = 16'h0000;
      exec_wdata = 8'h00;
      dma_page   = 8'h00;
      reset_n    = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
      chk("rst_exec_gnt", {31'd0, exec_gnt}, 32'd0);
      chk("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
      chk("rst_dma_busy", {31'd0, dma_busy}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst_owner", {30'd0, rdata_owner}, 32'd0);

      // Single fetch read
      reset_n    = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 16'h8000;
      #1;
      chk("fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
      chk("fetch_exec_gnt", {31'd0, exec_gnt}, 32'd0);
      chk("fetch_addr", {16'd0, bus_addr}, 32'h8000);
      chk("fetch_we", {31'd0, bus_we}, 32'd0);
      cyc();
      fetch_req = 1'b0;
      #1;
      chk("fetch_owner", {30'd0, rdata_owner}, 32'd1);
      cyc();
      #1;
      chk("owner_clear", {30'd0, rdata_owner}, 32'd0);

      // Exec vs fetch with starvation guard: E E E E F E
      fetch_req = 1'b1;
      exec_req  = 1'b1;
      exec_we   = 1'b0;
      exec_addr = 16'h0010;
      exp_e     = 6'b101111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("starve_exec", {31'd0, exec_gnt}, {31'd0, exp_e[i]});
         chk("starve_fetch", {31'd0, fetch_gnt}, {31'd0, ~exp_e[i]});
         chk("starve_addr", {16'd0, bus_addr}, exp_e[i] ? 32'h0010 : 32'h8000);
         if (i > 0) chk("starve_owner", {30'd0, rdata_owner}, exp_e[i-1] ? 32'd2 : 32'd1);
         cyc();
      end
      idle_inputs();
      #1;
      chk("exec_read_owner", {30'd0, rdata_owner}, 32'd2);

      // Exec write
      exec_req   = 1'b1;
      exec_we    = 1'b1;
      exec_addr  = 16'h0200;
      exec_wdata = 8'h55;
      #1;
      chk("wr_gnt", {31'd0, exec_gnt}, 32'd1);
      chk("wr_we", {31'd0, bus_we}, 32'd1);
      chk("wr_data", {24'd0, bus_wdata}, 32'h55);
      chk("wr_addr", {16'd0, bus_addr}, 32'h0200);
      cyc();
      idle_inputs();
      #1;
      chk("wr_we_drop", {31'd0, bus_we}, 32'd0);
      chk("wr_data_drop", {24'd0, bus_wdata}, 32'd0);
      chk("wr_owner", {30'd0, rdata_owner}, 32'd0);
      chk("wr_mem", {24'd0, wmem[16'h0200]}, 32'h55);

      // DMA with the HALT cycle on parity 0: no ALIGN, 513 busy cycles
      cyc();
      if (tb_par !== 1'b1) cyc();
      fetch_req  = 1'b1;
      fetch_addr = 16'h8000;
      dma_page   = 8'h02;
      dma_start  = 1'b1;
      #1;
      chk("dma1_start_idle", {31'd0, cpu_halt}, 32'd0);
      cyc();
      dma_start = 1'b0;
      run_dma(513, 1);

      // DMA issued together with an exec write, HALT on parity 1: ALIGN, 514 cycles
      idle_inputs();
      cyc();
      cyc();
      if (tb_par !== 1'b0) cyc();
      exec_req   = 1'b1;
      exec_we    = 1'b1;
      exec_addr  = 16'h0300;
      exec_wdata = 8'hAA;
      dma_start  = 1'b1;
      #1;
      chk("dma2_wr_gnt", {31'd0, exec_gnt}, 32'd1);
      chk("dma2_wr_we", {31'd0, bus_we}, 32'd1);
      cyc();
      idle_inputs();
      fetch_req = 1'b1;
      run_dma(514, 2);
      chk("dma2_wr_mem", {24'd0, wmem[16'h0300]}, 32'hAA);

      // Store finishing in HALT, ignored restart, reset at idx 100
      idle_inputs();
      cyc();
      cyc();
      fetch_req = 1'b1;
      dma_page  = 8'h02;
      dma_start = 1'b1;
      #1;
      cyc();
      dma_start  = 1'b0;
      exec_req   = 1'b1;
      exec_we    = 1'b1;
      exec_addr  = 16'h0400;
      exec_wdata = 8'h77;
      #1;
      chk("halt_wr_gnt", {31'd0, exec_gnt}, 32'd1);
      chk("halt_wr_we", {31'd0, bus_we}, 32'd1);
      chk("halt_wr_addr", {16'd0, bus_addr}, 32'h0400);
      chk("halt_no_fetch", {31'd0, fetch_gnt}, 32'd0);
      chk("halt_cpu_halt", {31'd0, cpu_halt}, 32'd1);
      cyc();
      exec_we   = 1'b0;
      exec_addr = 16'h0010;
      dma_page  = 8'h07;
      dma_start = 1'b1;
      #1;
      chk("halt_rd_denied", {31'd0, exec_gnt}, 32'd0);
      chk("halt_cpu_halt2", {31'd0, cpu_halt}, 32'd1);
      cyc();
      dma_start = 1'b0;
      found = 1'b0;
      wcnt6 = 0;
      n6    = 0;
      while (!found && n6 < 400) begin
         #1;
         if (bus_we === 1'b0 && bus_addr === 16'h0264) begin
            found = 1'b1;
         end else begin
            if (bus_we === 1'b1) wcnt6++;
            n6++;
            cyc();
         end
      end
      chk("rst_dma_found_idx100", {31'd0, found}, 32'd1);
      chk("rst_dma_writes", wcnt6, 100);
      chk("rst_dma_exec_denied", {31'd0, exec_gnt}, 32'd0);
      reset_n = 1'b0;
      cyc();
      #1;
      chk("rst_dma_busy", {31'd0, dma_busy}, 32'd0);
      chk("rst_dma_halt", {31'd0, cpu_halt}, 32'd0);
      chk("rst_dma_we", {31'd0, bus_we}, 32'd0);
      chk("rst_dma_exec_gnt", {31'd0, exec_gnt}, 32'd0);
      chk("rst_dma_owner", {30'd0, rdata_owner}, 32'd0);
      reset_n = 1'b1;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("post_rst_we", {31'd0, bus_we}, 32'd0);
         chk("post_rst_busy", {31'd0, dma_busy}, 32'd0);
         cyc();
      end
      chk("halt_wr_mem", {24'd0, wmem[16'h0400]}, 32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
